// File: rtl/ghash_pkg.sv
// ghash_pkg: shared GHASH constants, FSM encoding and the bit-serial multiply step.
package ghash_pkg;
    localparam int NB_DATA = 128;
    localparam logic [NB_DATA-1:0] R = 128'hE100_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [NB_DATA-1:0] ZERO = '0;

    typedef enum logic [1:0] {IDLE, MULT, WRITE} state_t;

    typedef struct packed {
        logic [NB_DATA-1:0] z;
        logic [NB_DATA-1:0] v;
        logic [NB_DATA-1:0] x;
    } gf_stage_t;

    // Advances the GCM shift-and-add multiply by n bits; x is consumed MSB first (x^0 coefficient first).
    function automatic gf_stage_t gf_steps(gf_stage_t s, int n);
        for (int i = 0; i < NB_DATA; i++) begin
            s.z = (i < n && s.x[NB_DATA-1]) ? s.z ^ s.v : s.z;
            s.v = (i < n) ? (s.v[0] ? (s.v >> 1) ^ R : s.v >> 1) : s.v;
            s.x = (i < n) ? s.x << 1 : s.x;
        end
        return s;
    endfunction
endpackage

// File: rtl/ghash_mult_sched_if.sv
// ghash_mult_sched_if: block handshake, H load and tag outputs of the GHASH sequencer.
interface ghash_mult_sched_if import ghash_pkg::*; ();
    logic [NB_DATA-1:0] i_h_key;
    logic               i_h_load;
    logic [NB_DATA-1:0] i_data;
    logic               i_valid;
    logic               i_last;
    logic               o_ready;
    logic [NB_DATA-1:0] o_tag;
    logic               o_tag_valid;
    logic               o_busy;

    modport master (
        output i_h_key, i_h_load, i_data, i_valid, i_last,
        input  o_ready, o_tag, o_tag_valid, o_busy
    );
    modport slave (
        input  i_h_key, i_h_load, i_data, i_valid, i_last,
        output o_ready, o_tag, o_tag_valid, o_busy
    );
endinterface

// File: rtl/gf128_mult_pipe.sv
// gf128_mult_pipe: GF(2^128) multiply with reduction, spread evenly over MULT_LATENCY register stages.
module gf128_mult_pipe import ghash_pkg::*; #(
    parameter int MULT_LATENCY = 4
) (
    input  logic               i_clock,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    output logic [NB_DATA-1:0] o_data
);
    localparam int K = (NB_DATA + MULT_LATENCY - 1) / MULT_LATENCY;

    gf_stage_t st_d [MULT_LATENCY];
    gf_stage_t st_q [MULT_LATENCY];

    for (genvar s = 0; s < MULT_LATENCY; s++) begin : g_stage
        localparam int N = ((s + 1) * K > NB_DATA) ? NB_DATA - s * K : K;
        if (s == 0) begin : g_first
            always_comb st_d[s] = gf_steps('{z: ZERO, v: i_data_b, x: i_data_a}, N);
        end else begin : g_next
            always_comb st_d[s] = gf_steps(st_q[s-1], N);
        end
        always_ff @(posedge i_clock) st_q[s] <= st_d[s];
    end

    assign o_data = st_q[MULT_LATENCY-1].z;
endmodule

// File: rtl/ghash_mult_sched.sv
// ghash_mult_sched: GHASH accumulator Y = (Y ^ X) * H sequenced around a fixed-latency multiplier.
module ghash_mult_sched import ghash_pkg::*; #(
    parameter int MULT_LATENCY = 4,
    parameter int NB_CNT       = 3
) (
    input  logic             i_clock,
    input  logic             i_reset,
    ghash_mult_sched_if.slave bus
);
    state_t             state_q, state_d;
    logic [NB_DATA-1:0] y_q, y_d, h_q, h_d, a_q, a_d, b_q, b_d, tag_q, tag_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [NB_DATA-1:0] product;
    logic               ready, accept, tag_now;

    gf128_mult_pipe #(.MULT_LATENCY(MULT_LATENCY)) u_mult (
        .i_clock (i_clock),
        .i_data_a(a_q),
        .i_data_b(b_q),
        .o_data  (product)
    );

    always_comb begin
        ready   = state_q == IDLE && !bus.i_h_load;
        accept  = ready && bus.i_valid;
        tag_now = state_q == WRITE && last_q;
        state_d = state_q;
        y_d     = y_q;
        h_d     = (state_q == IDLE && bus.i_h_load) ? bus.i_h_key : h_q;
        a_d     = accept ? y_q ^ bus.i_data : a_q;
        b_d     = accept ? h_q : b_q;
        last_d  = accept ? bus.i_last : last_q;
        cnt_d   = accept ? '0 : cnt_q;
        tag_d   = tag_now ? product : tag_q;
        if (accept) state_d = MULT;
        if (state_q == MULT) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == NB_CNT'(MULT_LATENCY - 1)) ? WRITE : MULT;
        end
        if (state_q == WRITE) begin
            y_d     = last_q ? ZERO : product;
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            y_q     <= ZERO;
            h_q     <= ZERO;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            tag_q   <= ZERO;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            tag_q   <= tag_d;
        end
    end

    // Operands need no reset: the FSM never consumes a product it did not launch.
    always_ff @(posedge i_clock) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    // The tag is steered straight from the multiplier during the pulse, then held.
    assign bus.o_tag       = tag_now ? product : tag_q;
    assign bus.o_tag_valid = tag_now;
    assign bus.o_ready     = ready;
    assign bus.o_busy      = state_q == MULT;
endmodule

// File: tb/tb_ghash_mult_sched.sv
// tb_ghash_mult_sched: scoreboard bench against a polynomial-arithmetic GHASH model.
module tb_ghash_mult_sched;
    localparam int L = 4;

    typedef struct {
        logic [127:0] tag;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [127:0] ym = '0, hm = '0, hold_tag = '0;

    ghash_mult_sched_if bus ();

    ghash_mult_sched #(.MULT_LATENCY(L), .NB_CNT(3)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiply in ordinary polynomial order: reverse GCM bits, clmul, reduce by x^128+x^7+x^2+x+1.
    function automatic logic [127:0] rev(input logic [127:0] a);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = a[127-i];
        return r;
    endfunction

    function automatic logic [127:0] gmul(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] p, pa, pb, poly;
        p    = '0;
        pa   = {128'b0, rev(a)};
        pb   = {128'b0, rev(b)};
        poly = {127'b0, 1'b1, 128'h87};
        for (int i = 0; i < 128; i++) if (pa[i]) p ^= pb << i;
        for (int i = 255; i >= 128; i--) if (p[i]) p ^= poly << (i - 128);
        return rev(p[127:0]);
    endfunction

    task automatic garbage();
        bus.i_data   = {$urandom, $urandom, $urandom, $urandom};
        bus.i_h_key  = {$urandom, $urandom, $urandom, $urandom};
        bus.i_last   = 1'($urandom);
        bus.i_valid  = 1'($urandom);
        bus.i_h_load = 1'($urandom);
    endtask

    task automatic load_h(input logic [127:0] h);
        bus.i_h_load = 1'b1;
        bus.i_h_key  = h;
        bus.i_valid  = 1'b0;
        @(posedge clk); #1;
        bus.i_h_load = 1'b0;
        hm = h;
    endtask

    // Presents one block, waits for acceptance, then checks the busy gap while scrambling inputs.
    task automatic send(input logic [127:0] x, input bit last, input bit use_exp, input logic [127:0] exp);
        int n = 0;
        exp_t e;
        bus.i_data  = x;
        bus.i_last  = last;
        bus.i_valid = 1'b1;
        @(negedge clk);
        while (!bus.o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", 128'(n), 128'(0));
        end else begin
            ym = gmul(ym ^ x, hm);
            if (last) begin
                e.tag = use_exp ? exp : ym;
                e.cyc = cyc;
                sb.push_back(e);
                ym = '0;
            end
        end
        @(posedge clk); #1;
        for (int k = 1; k <= L + 1; k++) begin
            garbage();
            @(negedge clk);
            chk("ready_low_gap", 128'(bus.o_ready), 128'(0));
            chk("busy_gap", 128'(bus.o_busy), 128'(k <= L));
            @(posedge clk); #1;
        end
        bus.i_valid  = 1'b0;
        bus.i_h_load = 1'b0;
        @(negedge clk);
        chk("ready_after_gap", 128'(bus.o_ready), 128'(1));
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_tag = '0;
        end else if (bus.o_tag_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_tag_valid", 128'(bus.o_tag_valid), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tag_value", bus.o_tag, e.tag);
                chk("tag_latency", 128'(cyc), 128'(e.cyc + L + 1));
                hold_tag = e.tag;
            end
        end else begin
            chk("tag_hold", bus.o_tag, hold_tag);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_h_key  = '0;
        bus.i_h_load = 1'b0;
        bus.i_data   = '0;
        bus.i_valid  = 1'b0;
        bus.i_last   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 128'(bus.o_ready), 128'(1));
        chk("reset_busy", 128'(bus.o_busy), 128'(0));
        chk("reset_tag_valid", 128'(bus.o_tag_valid), 128'(0));
        chk("reset_tag", bus.o_tag, '0);
        @(posedge clk); #1;

        load_h(128'h8000_0000_0000_0000_0000_0000_0000_0000);
        send(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1, 1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210);

        load_h(128'h4000_0000_0000_0000_0000_0000_0000_0000);
        send(128'h1, 1'b1, 1'b1, 128'hE100_0000_0000_0000_0000_0000_0000_0000);

        load_h(128'h8000_0000_0000_0000_0000_0000_0000_0000);
        send(128'hFF00_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, '0);
        send(128'h0F00_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, '0);
        send(128'h1, 1'b1, 1'b1, 128'hF000_0000_0000_0000_0000_0000_0000_0001);
        send({32{4'hA}}, 1'b1, 1'b1, {32{4'hA}});

        // H load and a block in the same IDLE cycle: load wins, block goes next cycle with new H.
        bus.i_data   = 128'h1;
        bus.i_last   = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_h_load = 1'b1;
        bus.i_h_key  = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
        @(negedge clk);
        chk("contention_ready", 128'(bus.o_ready), 128'(0));
        @(posedge clk); #1;
        bus.i_h_load = 1'b0;
        hm = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
        send(128'h1, 1'b1, 1'b1, 128'hE100_0000_0000_0000_0000_0000_0000_0000);

        // Reset while the counter is at 1: the in-flight product must vanish.
        load_h(128'h8000_0000_0000_0000_0000_0000_0000_0000);
        bus.i_data  = 128'h5;
        bus.i_last  = 1'b1;
        bus.i_valid = 1'b1;
        @(negedge clk);
        chk("abort_accept_ready", 128'(bus.o_ready), 128'(1));
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 128'(bus.o_busy), 128'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        ym = '0;
        hm = '0;
        @(negedge clk);
        chk("post_reset_ready", 128'(bus.o_ready), 128'(1));
        chk("post_reset_busy", 128'(bus.o_busy), 128'(0));
        chk("post_reset_tag", bus.o_tag, '0);
        @(posedge clk); #1;
        send(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1, 1'b1, '0);
        load_h(128'h8000_0000_0000_0000_0000_0000_0000_0000);
        send(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1, 1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210);

        for (int m = 0; m < 1000; m++) begin
            int nb;
            load_h({$urandom, $urandom, $urandom, $urandom});
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++)
                send({$urandom, $urandom, $urandom, $urandom}, b == nb - 1, 1'b0, '0);
        end

        repeat (10) @(posedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
